// File: rtl/top_varint_if.sv
// Field-in / record-out bundle between the field scheduler, the varint encoder and the byte packer.
// Latency: none (wires only); the encoder owns the single register stage.
// Backpressure: none; a field may be offered every cycle and the result must be consumed when out_valid is high.
//
// Signals:
//   in_valid, value[63:0], field_id[28:0], field_type[4:0]  -- field to encode (master -> slave)
//   out_valid, out_port[119:0], out_len[3:0], out_err       -- encoded record (slave -> master)
interface top_varint_if;
    logic         in_valid;
    logic [63:0]  value;
    logic [28:0]  field_id;
    logic [4:0]   field_type;
    logic         out_valid;
    logic [119:0] out_port;
    logic [3:0]   out_len;
    logic         out_err;

    // master: field scheduler side (drives the field, receives the record)
    modport master (
        output in_valid, value, field_id, field_type,
        input  out_valid, out_port, out_len, out_err
    );

    // slave: encoder side
    modport slave (
        input  in_valid, value, field_id, field_type,
        output out_valid, out_port, out_len, out_err
    );
endinterface

// File: rtl/top_varint.sv
// Protobuf varint field encoder: tag varint + value varint, left-justified in a 15-byte record.
// Latency: 1 cycle (combinational encode, one output register stage).
// Backpressure: none; a new field may be accepted every cycle, outputs hold while in_valid is low.
//
// Ports:
//   clk  -- rising-edge clock
//   rst  -- synchronous active-high reset, has priority over in_valid
//   bus  -- top_varint_if.slave: in_valid/value/field_id/field_type in,
//           out_valid/out_port/out_len/out_err out
module top_varint (
    input  logic        clk,
    input  logic        rst,
    top_varint_if.slave bus
);

    // Number of 7-bit groups needed for u; zero still takes one byte.
    function automatic logic [3:0] varint_len(input logic [63:0] u);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 1; i < 10; i++) begin
            if ((u >> (7 * i)) != 64'd0) begin
                n = 4'(i + 1);
            end
        end
        return n;
    endfunction

    // Varint bytes left-justified: byte 0 (least significant group) in [79:72].
    // Continuation bit is set on every emitted byte except the last; bytes past len stay zero.
    function automatic logic [79:0] varint_bytes(input logic [63:0] u, input logic [3:0] len);
        logic [69:0] ux;
        logic [79:0] r;
        ux = {6'd0, u};
        r  = '0;
        for (int i = 0; i < 10; i++) begin
            if (4'(i) < len) begin
                r[79 - 8 * i -: 8] = {(4'(i + 1) < len), ux[7 * i +: 7]};
            end
        end
        return r;
    endfunction

    logic [63:0]  val_u;
    logic         type_ok;
    logic [31:0]  zz32;
    logic [63:0]  tag_u;
    logic [3:0]   tag_len;
    logic [79:0]  tag_b;
    logic [3:0]   val_len;
    logic [79:0]  val_b;
    logic [119:0] rec;

    logic [119:0] out_port_d, out_port_q;
    logic [3:0]   out_len_d,  out_len_q;
    logic         out_err_d,  out_err_q;
    logic         out_valid_q;

    always_comb begin
        val_u   = '0;
        type_ok = 1'b1;
        // zigzag of the low 32 bits: (v << 1) ^ (v >>> 31)
        zz32    = {bus.value[30:0], 1'b0} ^ {32{bus.value[31]}};

        case (bus.field_type)
            5'd3, 5'd4:   val_u = bus.value;
            5'd5, 5'd14:  val_u = {{32{bus.value[31]}}, bus.value[31:0]};
            5'd13:        val_u = {32'd0, bus.value[31:0]};
            5'd8:         val_u = {63'd0, (bus.value != 64'd0)};
            5'd17:        val_u = {32'd0, zz32};
            5'd18:        val_u = {bus.value[62:0], 1'b0} ^ {64{bus.value[63]}};
            default:      type_ok = 1'b0;
        endcase

        // Wire type is always 0, so the tag is just the field number shifted by 3.
        tag_u   = {32'd0, bus.field_id, 3'b000};
        tag_len = varint_len(tag_u);
        tag_b   = varint_bytes(tag_u, tag_len);
        val_len = varint_len(val_u);
        val_b   = varint_bytes(val_u, val_len);

        // A 32-bit tag never exceeds 5 bytes, so tag_b[39:0] is always zero and the
        // value bytes slide in directly behind the tag.
        rec = {tag_b, 40'd0} | ({val_b, 40'd0} >> {tag_len, 3'b000});

        out_err_d  = !type_ok;
        out_port_d = type_ok ? rec : '0;
        out_len_d  = type_ok ? (tag_len + val_len) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_port_q  <= '0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_port_q <= out_port_d;
                out_len_q  <= out_len_d;
                out_err_q  <= out_err_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_port  = out_port_q;
    assign bus.out_len   = out_len_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_top_varint.sv
// Testbench for top_varint: directed wire-format vectors, randomized fields against a
// byte-queue reference model, back-to-back traffic, and error/hold/reset sequencing.
module tb_top_varint;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    top_varint_if bus ();

    top_varint dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: protobuf rules with signed arithmetic and a byte queue.
    function automatic void model(input logic [63:0] value, input logic [28:0] fid,
                                  input logic [4:0] ft, output logic [119:0] port,
                                  output logic [3:0] len, output logic err);
        logic [63:0] u;
        logic [63:0] t;
        longint      sv;
        logic        ok;
        logic [7:0]  b;
        logic [7:0]  q[$];
        ok = 1'b1;
        u  = 64'd0;
        case (ft)
            5'd3, 5'd4:  u = value;
            5'd5, 5'd14: begin sv = int'(value[31:0]); u = sv; end
            5'd13:       u = {32'd0, value[31:0]};
            5'd8:        u = (value != 64'd0) ? 64'd1 : 64'd0;
            5'd17: begin
                sv = int'(value[31:0]);
                u  = (sv >= 0) ? 64'(2 * sv) : 64'(-2 * sv - 1);
            end
            5'd18: begin
                sv = value;
                u  = (sv >= 0) ? 64'(2 * sv) : 64'(-2 * sv - 1);
            end
            default: ok = 1'b0;
        endcase
        t = 64'(fid) * 8;
        do begin
            b = {1'b0, t[6:0]};
            t = t >> 7;
            if (t != 0) b[7] = 1'b1;
            q.push_back(b);
        end while (t != 0);
        do begin
            b = {1'b0, u[6:0]};
            u = u >> 7;
            if (u != 0) b[7] = 1'b1;
            q.push_back(b);
        end while (u != 0);
        port = '0;
        for (int k = 0; k < q.size(); k++) port[119 - 8 * k -: 8] = q[k];
        len = 4'(q.size());
        err = 1'b0;
        if (!ok) begin
            port = '0;
            len  = 4'd0;
            err  = 1'b1;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.value = '0;
        bus.field_id = '0;
        bus.field_type = '0;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_port !== 120'd0) $display("FAIL reset_port: got %h want 0", bus.out_port); else pass_cnt++;
        total_cnt++; if (bus.out_len !== 4'd0) $display("FAIL reset_len: got %0d want 0", bus.out_len); else pass_cnt++;
        total_cnt++; if (bus.out_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.out_err); else pass_cnt++;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [63:0]  v;
        logic [28:0]  f;
        logic [4:0]   t;
        logic [119:0] p;
        logic [3:0]   l;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[9];
        vecs[0] = '{64'd150, 29'd1, 5'd5, {24'h089601, 96'd0}, 4'd3};
        vecs[1] = '{-64'sd2, 29'd2, 5'd18, {16'h1003, 104'd0}, 4'd2};
        vecs[2] = '{-64'sd2, 29'd2, 5'd5, {88'h10FEFFFFFFFFFFFFFFFF01, 32'd0}, 4'd11};
        vecs[3] = '{64'd2, 29'd2, 5'd18, {16'h1004, 104'd0}, 4'd2};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 29'h1FFF_FFFF, 5'd4,
                    {40'hF8FFFFFF0F, 72'hFFFFFFFFFFFFFFFFFF, 8'h01}, 4'd15};
        vecs[5] = '{64'd0, 29'd0, 5'd8, {16'h0000, 104'd0}, 4'd2};
        vecs[6] = '{64'd5, 29'd3, 5'd8, {16'h1801, 104'd0}, 4'd2};
        vecs[7] = '{64'hFFFF_FFFF_0000_0080, 29'd1, 5'd13, {24'h088001, 96'd0}, 4'd3};
        vecs[8] = '{64'h0000_0000_FFFF_FFFF, 29'd16, 5'd17, {24'h800101, 96'd0}, 4'd3};
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            bus.in_valid   = 1'b1;
            bus.value      = vecs[i].v;
            bus.field_id   = vecs[i].f;
            bus.field_type = vecs[i].t;
            @(negedge clk);
            total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL dir%0d_valid: got %b want 1", i, bus.out_valid); else pass_cnt++;
            total_cnt++; if (bus.out_port !== vecs[i].p) $display("FAIL dir%0d_port: got %h want %h", i, bus.out_port, vecs[i].p); else pass_cnt++;
            total_cnt++; if (bus.out_len !== vecs[i].l) $display("FAIL dir%0d_len: got %0d want %0d", i, bus.out_len, vecs[i].l); else pass_cnt++;
            total_cnt++; if (bus.out_err !== 1'b0) $display("FAIL dir%0d_err: got %b want 0", i, bus.out_err); else pass_cnt++;
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [4:0] pick_type();
        logic [4:0] types [8] = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18};
        if ($urandom_range(0, 4) == 0) return 5'($urandom);
        return types[$urandom_range(0, 7)];
    endfunction

    // Random fields with random idle gaps; the model holds its last result across gaps.
    task automatic run_stream(input string tag, input int n_items, input bit always_valid);
        logic         exp_v;
        logic [119:0] exp_p;
        logic [3:0]   exp_l;
        logic         exp_e;
        exp_v = 1'b0; exp_p = '0; exp_l = '0; exp_e = 1'b0;
        for (int n = 0; n <= n_items; n++) begin
            @(negedge clk);
            if (n > 0) begin
                total_cnt++; if (bus.out_valid !== exp_v) $display("FAIL %s%0d_valid: got %b want %b", tag, n, bus.out_valid, exp_v); else pass_cnt++;
                total_cnt++; if (bus.out_port !== exp_p) $display("FAIL %s%0d_port: got %h want %h", tag, n, bus.out_port, exp_p); else pass_cnt++;
                total_cnt++; if (bus.out_len !== exp_l) $display("FAIL %s%0d_len: got %0d want %0d", tag, n, bus.out_len, exp_l); else pass_cnt++;
                total_cnt++; if (bus.out_err !== exp_e) $display("FAIL %s%0d_err: got %b want %b", tag, n, bus.out_err, exp_e); else pass_cnt++;
            end
            if (n < n_items) begin
                bus.in_valid   = (always_valid || n == 0) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
                bus.value      = {$urandom, $urandom} >> $urandom_range(0, 63);
                bus.field_id   = 29'($urandom >> $urandom_range(0, 31));
                bus.field_type = pick_type();
                exp_v = bus.in_valid;
                if (bus.in_valid) model(bus.value, bus.field_id, bus.field_type, exp_p, exp_l, exp_e);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        run_stream("rand", 300, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_stream("b2b", 200, 1'b1);
    endtask

    task automatic test_err_hold_reset();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.value = 64'd150; bus.field_id = 29'd1; bus.field_type = 5'd5;
        @(negedge clk);
        total_cnt++; if (bus.out_port !== {24'h089601, 96'd0}) $display("FAIL ehr_load_port: got %h want 089601..", bus.out_port); else pass_cnt++;
        bus.in_valid = 1'b0; bus.value = 64'd7; bus.field_id = 29'd9; bus.field_type = 5'd9;
        @(negedge clk);
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL hold_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_port !== {24'h089601, 96'd0}) $display("FAIL hold_port: got %h want 089601..", bus.out_port); else pass_cnt++;
        total_cnt++; if (bus.out_len !== 4'd3) $display("FAIL hold_len: got %0d want 3", bus.out_len); else pass_cnt++;
        bus.in_valid = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.out_err !== 1'b1) $display("FAIL err_flag: got %b want 1", bus.out_err); else pass_cnt++;
        total_cnt++; if (bus.out_port !== 120'd0) $display("FAIL err_port: got %h want 0", bus.out_port); else pass_cnt++;
        total_cnt++; if (bus.out_len !== 4'd0) $display("FAIL err_len: got %0d want 0", bus.out_len); else pass_cnt++;
        total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL err_valid: got %b want 1", bus.out_valid); else pass_cnt++;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL errhold_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_err !== 1'b1) $display("FAIL errhold_err: got %b want 1", bus.out_err); else pass_cnt++;
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.value = 64'd150; bus.field_id = 29'd1; bus.field_type = 5'd5;
        @(negedge clk);
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rstpri_valid: got %b want 0", bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_port !== 120'd0) $display("FAIL rstpri_port: got %h want 0", bus.out_port); else pass_cnt++;
        total_cnt++; if (bus.out_len !== 4'd0) $display("FAIL rstpri_len: got %0d want 0", bus.out_len); else pass_cnt++;
        total_cnt++; if (bus.out_err !== 1'b0) $display("FAIL rstpri_err: got %b want 0", bus.out_err); else pass_cnt++;
        rst = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_err_hold_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/top_varint.md
Name: top_varint

Overview:
Protocol Buffers varint field encoder. It takes a field number, a descriptor field type and a 64-bit value, and emits the complete wire-format record as a left-justified byte string: tag varint followed by value varint. It sits in the serializer datapath between the field scheduler and the output byte packer. The datapath is combinational, followed by one register stage.

Parameters:
None. All widths are fixed by the protobuf wire format.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input fields are valid; the encoder captures a result this cycle
value  input  64  raw field value (two's complement for signed types)
field_id  input  29  protobuf field number
field_type  input  5  descriptor type code
out_valid  output  1  out_port, out_len and out_err hold a fresh result
out_port  output  120  encoded record; byte 0 in [119:112], byte k in [119-8k:112-8k]; unused trailing bytes are 0
out_len  output  4  number of valid bytes in out_port (0..15)
out_err  output  1  field_type is not a varint type

Behaviour:
- Reset (rst=1 at a clock edge): out_port=0, out_len=0, out_valid=0, out_err=0. Reset has priority over in_valid.
- Latency is 1 cycle: the result for inputs sampled with in_valid=1 at edge N is visible after edge N.
- out_valid is the registered in_valid. When in_valid=0, out_port, out_len and out_err hold their last values.
- Tag:
  - tag = {field_id, 3'b000}, 32 bits; wire type is always 0 (varint).
  - The tag is varint-encoded into 1..5 bytes.
  - field_id=0 is encoded literally (tag byte 0x00) and does not raise an error.
- Value mapping by field_type, giving a 64-bit unsigned u:
  - 3 int64, 4 uint64: u = value
  - 5 int32, 14 enum: u = sign-extend(value[31:0]), so negatives encode as 10 bytes
  - 13 uint32: u = zero-extend(value[31:0])
  - 8 bool: u = (value != 0)
  - 17 sint32: u = zero-extend((v<<1) ^ (v>>>31)), where v = value[31:0]
  - 18 sint64: u = (value<<1) ^ (value>>>63)
- Varint encoding:
  - Groups of 7 bits, least significant first.
  - Bit 7 of each byte is set except on the last byte.
  - Minimal length: 1 byte when u=0, at most 10 bytes.
- Output assembly:
  - Tag bytes come first, then value bytes; the rest of out_port is zero-filled.
  - out_len = tag_len + val_len, at most 5+10 = 15.
- Unsupported field_type (any code not listed above): out_err=1, out_port=0, out_len=0, out_valid still follows in_valid.
- Back-to-back in_valid is allowed every cycle; there is no backpressure.

Test Plan:
- value=150, field_id=1, type=5, in_valid=1 -> next cycle out_port=0x089601 followed by 12 zero bytes, out_len=3, out_err=0.
- value=-2, field_id=2, type=18 -> out_port=0x1003 followed by zeros, out_len=2.
- value=-2, field_id=2, type=5 -> out_port bytes 10 FE FF FF FF FF FF FF FF FF 01 then 4 zero bytes, out_len=11.
- value=2, field_id=2, type=18 -> out_port=0x1004 followed by zeros, out_len=2.
- Maximum-length case: field_id=0x1FFFFFFF, value=0xFFFFFFFFFFFFFFFF, type=4 -> bytes F8 FF FF FF 0F, then FF x9, then 01; out_len=15.
- Error, hold and reset sequence:
  - type=9 -> out_err=1, out_port=0, out_len=0.
  - Then deassert in_valid -> outputs hold and out_valid=0.
  - Then assert rst together with in_valid -> all outputs 0.
